norm_divider: RTL and testbench

//  Sequential signed fixed-point divider that consumes the log2 leading-one count of the

---
 rtl/norm_divider.sv | 182 ++++++++++++++++++
 tb/tb_norm_divider.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/norm_divider.sv
// norm_divider: sequential signed fixed-point divider.
// Computes quotient = num/den * 2^FRAC_BITS, truncated toward zero. Divisors wider
// than DEN_BITS significant bits are right-shifted together with the numerator,
// which keeps the restoring-division remainder short. One operation in flight.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   valid_in     operands valid, taken when ready_out is high
//   ready_out    idle and able to accept
//   num, den     signed WIDTH-bit operands
//   valid_out    one-cycle pulse, quotient/div_by_zero valid
//   quotient     signed result with FRAC_BITS fractional bits
//   div_by_zero  qualified by valid_out: den was zero
module norm_divider #(
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned DEN_BITS  = 10,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             valid_out,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero
);

  localparam int unsigned N  = WIDTH + FRAC_BITS;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned EW = $clog2(WIDTH + 1);
  localparam int unsigned RW = DEN_BITS + 1;

  // Largest positive magnitude; saturation is symmetric around zero.
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'((64'd1 << (WIDTH - 1)) - 64'd1);
  localparam logic [N-1:0]     MAX_N = N'(MAX_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORM   = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [WIDTH-1:0]    num_abs, num_abs_d;
  logic [WIDTH-1:0]    den_abs, den_abs_d;
  logic                neg, neg_d;
  logic [DEN_BITS-1:0] den_r, den_r_d;
  logic [N-1:0]        dq, dq_d;       // dividend shifts out the top, quotient bits enter the bottom
  logic [RW-1:0]       rem, rem_d;
  logic [CW-1:0]       count, count_d;
  logic                valid_out_d;
  logic [WIDTH-1:0]    quotient_d;
  logic                div_by_zero_d;

  // Datapath scratch values
  logic [EW-1:0]       e_c;
  logic [EW-1:0]       sh_c;
  logic [WIDTH-1:0]    num_r_c;
  logic [RW:0]         rem_sh_c;
  logic                qbit_c;
  logic [N-1:0]        mag_c;

  assign ready_out = (state == IDLE) && !rst;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      num_abs     <= '0;
      den_abs     <= '0;
      neg         <= 1'b0;
      den_r       <= '0;
      dq          <= '0;
      rem         <= '0;
      count       <= '0;
      valid_out   <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_d;
      num_abs     <= num_abs_d;
      den_abs     <= den_abs_d;
      neg         <= neg_d;
      den_r       <= den_r_d;
      dq          <= dq_d;
      rem         <= rem_d;
      count       <= count_d;
      valid_out   <= valid_out_d;
      quotient    <= quotient_d;
      div_by_zero <= div_by_zero_d;
    end
  end

  // Leading-one position of |den| plus one; zero when |den| is zero
  always_comb begin
    e_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (den_abs[i]) e_c = EW'(i + 1);
    end
  end

  // One restoring-division step
  always_comb begin
    rem_sh_c = {rem, dq[N-1]};
    qbit_c   = (rem_sh_c >= (RW + 1)'(den_r));
  end

  // Next-state and datapath control
  always_comb begin
    state_d       = state;
    num_abs_d     = num_abs;
    den_abs_d     = den_abs;
    neg_d         = neg;
    den_r_d       = den_r;
    dq_d          = dq;
    rem_d         = rem;
    count_d       = count;
    valid_out_d   = 1'b0;
    quotient_d    = quotient;
    div_by_zero_d = div_by_zero;
    sh_c          = '0;
    num_r_c       = '0;
    mag_c         = '0;

    unique case (state)
      IDLE: begin
        if (valid_in) begin
          // Two's-complement negate also maps the most negative value to 2^(WIDTH-1)
          num_abs_d = num[WIDTH-1] ? WIDTH'(-num) : num;
          den_abs_d = den[WIDTH-1] ? WIDTH'(-den) : den;
          neg_d     = num[WIDTH-1] ^ den[WIDTH-1];
          state_d   = NORM;
        end
      end

      NORM: begin
        if (e_c == '0) begin
          if (num_abs == '0) quotient_d = '0;
          else               quotient_d = neg ? WIDTH'(-MAX_W) : MAX_W;
          div_by_zero_d = 1'b1;
          valid_out_d   = 1'b1;
          state_d       = DONE;
        end else begin
          if (e_c > EW'(DEN_BITS)) sh_c = e_c - EW'(DEN_BITS);
          den_r_d       = DEN_BITS'(den_abs >> sh_c);
          num_r_c       = num_abs >> sh_c;
          dq_d          = {num_r_c, FRAC_BITS'(0)};
          rem_d         = '0;
          count_d       = '0;
          div_by_zero_d = 1'b0;
          state_d       = DIVIDE;
        end
      end

      DIVIDE: begin
        rem_d   = qbit_c ? RW'(rem_sh_c - (RW + 1)'(den_r)) : RW'(rem_sh_c);
        dq_d    = {dq[N-2:0], qbit_c};
        count_d = count + CW'(1);
        if (count == CW'(N - 1)) begin
          mag_c = {dq[N-2:0], qbit_c};
          if (mag_c > MAX_N) mag_c = MAX_N;
          quotient_d  = (neg && (mag_c != '0)) ? WIDTH'(-mag_c) : WIDTH'(mag_c);
          valid_out_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_norm_divider.sv
// Scoreboard bench for norm_divider: stimulus pushes expected results at accept,
// a negedge monitor pops and checks quotient, div_by_zero and latency.
module tb_norm_divider;

  localparam int unsigned W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] num_in;
  logic [W-1:0] den_in;
  logic         valid_out;
  logic [W-1:0] quotient;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic signed [W-1:0] q;
    logic                z;
    int                  lat;
    int                  acc;
    int                  id;
  } exp_t;

  exp_t sb[$];

  norm_divider #(.WIDTH(20), .DEN_BITS(10), .FRAC_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .num         (num_in),
    .den         (den_in),
    .valid_out   (valid_out),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid_out: quotient %0d with no pending op", $signed(quotient));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d_quotient", e.id), int'($signed(quotient)), int'(e.q));
        check($sformatf("op%0d_div_by_zero", e.id), int'(div_by_zero), int'(e.z));
        check($sformatf("op%0d_latency", e.id), cyc - e.acc + 1, e.lat);
      end
    end
  end

  int op_id = 0;

  // Issue one op; optionally keep valid_in high with other operands for 'hold' cycles while busy
  task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                        input logic signed [W-1:0] eq, input logic ez, input int el,
                        input int hold);
    int guard;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (!ready_out && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_out) begin
      check("ready_wait", int'(ready_out), 1);
      return;
    end
    num_in   = a;
    den_in   = b;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    e.q   = eq;
    e.z   = ez;
    e.lat = el;
    e.acc = cyc;
    e.id  = op_id;
    op_id++;
    sb.push_back(e);
    if (hold > 0) begin
      num_in = 20'sd1;
      den_in = 20'sd1;
      repeat (hold) @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    num_in   = '0;
    den_in   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    check("reset_ready_out", int'(ready_out), 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", int'(ready_out), 1);

    // Busy-hold: extra valid_in with new operands during the op is ignored
    run_op(20'sd100, 20'sd4, 20'sd6400, 1'b0, 30, 15);
    run_op(-20'sd300, 20'sd7, -20'sd10971, 1'b0, 30, 0);
    run_op(20'sd0, -20'sd5, 20'sd0, 1'b0, 30, 0);
    run_op(20'sd5, 20'sd0, 20'sd524287, 1'b1, 2, 0);
    run_op(-20'sd5, 20'sd0, -20'sd524287, 1'b1, 2, 0);
    run_op(20'sd0, 20'sd0, 20'sd0, 1'b1, 2, 0);
    run_op(20'sd400000, 20'sd300000, 20'sd341, 1'b0, 30, 0);
    run_op(20'sd200000, 20'sd1, 20'sd524287, 1'b0, 30, 0);
    run_op(-20'sd524288, 20'sd1, -20'sd524287, 1'b0, 30, 0);
    run_op(20'sd1000, -20'sd3, -20'sd85333, 1'b0, 30, 0);
    run_op(-20'sd7, -20'sd2, 20'sd896, 1'b0, 30, 0);
    run_op(20'sd1023, 20'sd1023, 20'sd256, 1'b0, 30, 0);
    run_op(20'sd1024, 20'sd1024, 20'sd256, 1'b0, 30, 0);

    // Abort an op with reset at cycle 10; no result may come out of it
    @(negedge clk);
    num_in   = 20'sd1000;
    den_in   = 20'sd3;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_in_reset", int'(ready_out), 0);
    check("abort_quotient_cleared", int'(quotient), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ready_after_reset", int'(ready_out), 1);
    run_op(20'sd1000, 20'sd3, 20'sd85333, 1'b0, 30, 0);

    repeat (40) @(negedge clk);
    check("pending_at_end", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
